// File: rtl/cc_ballcontroller_jug2_if.sv
// Player-2 ball controller bus: player-1 handshake, button, side comparator and shift-register controls.
interface cc_ballcontroller_jug2_if #(
    parameter int BALLCONTROL_DATAWIDTH = 8
);
    logic                             CC_BALLCONTROL_handoff_InHigh;
    logic                             CC_BALLCONTROL_hit_InLow;
    logic                             CC_BALLCONTROL_izquierda_InLow;
    logic                             CC_BALLCONTROL_derecha_InLow;
    logic [1:0]                       CC_BALLCONTROL_shiftselection_OutBUS;
    logic [BALLCONTROL_DATAWIDTH-1:0] CC_BALLCONTROL_load_OutBUS;
    logic                             CC_BALLCONTROL_handoff_OutHigh;
    logic                             CC_BALLCONTROL_point_OutHigh;
    logic [2:0]                       CC_BALLCONTROL_state_OutBUS;

    // Controller side: drives the shift register, watches comparator and button.
    modport master (
        input  CC_BALLCONTROL_handoff_InHigh,
        input  CC_BALLCONTROL_hit_InLow,
        input  CC_BALLCONTROL_izquierda_InLow,
        input  CC_BALLCONTROL_derecha_InLow,
        output CC_BALLCONTROL_shiftselection_OutBUS,
        output CC_BALLCONTROL_load_OutBUS,
        output CC_BALLCONTROL_handoff_OutHigh,
        output CC_BALLCONTROL_point_OutHigh,
        output CC_BALLCONTROL_state_OutBUS
    );

    modport slave (
        output CC_BALLCONTROL_handoff_InHigh,
        output CC_BALLCONTROL_hit_InLow,
        output CC_BALLCONTROL_izquierda_InLow,
        output CC_BALLCONTROL_derecha_InLow,
        input  CC_BALLCONTROL_shiftselection_OutBUS,
        input  CC_BALLCONTROL_load_OutBUS,
        input  CC_BALLCONTROL_handoff_OutHigh,
        input  CC_BALLCONTROL_point_OutHigh,
        input  CC_BALLCONTROL_state_OutBUS
    );
endinterface

// File: rtl/cc_ballcontroller_jug2.sv
// Player-2 ball sequencer: serves the ball toward bit 0, opens a hit window, returns it or scores a miss.
// state       | meaning
// IDLE        | ball on player-1 side, waiting for handoff
// LOAD        | load ball at bit 3
// MOVE_RIGHT  | step ball toward the paddle each tick
// WAIT_HIT    | ball at bit 0, hit window open
// MOVE_LEFT   | step ball back toward player 1 each tick
// CLEAR       | empty this half, pulse handoff or point
module cc_ballcontroller_jug2 #(
    parameter int BALLCONTROL_DATAWIDTH = 8,
    parameter int BALLCONTROL_TICKDIV   = 25000000,
    parameter int BALLCONTROL_HITWINDOW = 2
) (
    input  logic                     CC_BALLCONTROL_CLOCK_50,
    input  logic                     CC_BALLCONTROL_RESET_InHigh,
    cc_ballcontroller_jug2_if.master bus
);

    localparam int TICKW = $clog2(BALLCONTROL_TICKDIV);
    localparam int WINW  = $clog2(BALLCONTROL_HITWINDOW + 1);
    localparam logic [TICKW-1:0] TICK_LAST = TICKW'(BALLCONTROL_TICKDIV - 1);
    localparam logic [WINW-1:0]  WIN_LAST  = WINW'(BALLCONTROL_HITWINDOW - 1);
    localparam logic [BALLCONTROL_DATAWIDTH-1:0] BALL_SERVE = BALLCONTROL_DATAWIDTH'(8);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_MOVE_RIGHT = 3'd2,
        ST_WAIT_HIT   = 3'd3,
        ST_MOVE_LEFT  = 3'd4,
        ST_CLEAR      = 3'd5
    } state_t;

    state_t                           r_state, w_state_next;
    logic [TICKW-1:0]                 r_tick_cnt, w_tick_cnt_next;
    logic [WINW-1:0]                  r_win_cnt, w_win_cnt_next;
    logic [1:0]                       r_shiftsel, w_shiftsel_next;
    logic [BALLCONTROL_DATAWIDTH-1:0] r_load, w_load_next;
    logic                             r_handoff_out, w_handoff_out_next;
    logic                             r_point, w_point_next;
    logic                             r_hit_meta, r_hit_sync, r_hit_prev;
    logic                             w_hit, w_tick;
    logic [TICKW-1:0]                 w_tick_inc;

    assign w_hit      = r_hit_prev & ~r_hit_sync;
    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_tick_inc = w_tick ? '0 : r_tick_cnt + 1'b1;

    always_ff @(posedge CC_BALLCONTROL_CLOCK_50 or posedge CC_BALLCONTROL_RESET_InHigh) begin
        if (CC_BALLCONTROL_RESET_InHigh) begin
            r_state       <= ST_IDLE;
            r_tick_cnt    <= '0;
            r_win_cnt     <= '0;
            r_shiftsel    <= 2'b00;
            r_load        <= '0;
            r_handoff_out <= 1'b0;
            r_point       <= 1'b0;
            r_hit_meta    <= 1'b1;
            r_hit_sync    <= 1'b1;
            r_hit_prev    <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_tick_cnt    <= w_tick_cnt_next;
            r_win_cnt     <= w_win_cnt_next;
            r_shiftsel    <= w_shiftsel_next;
            r_load        <= w_load_next;
            r_handoff_out <= w_handoff_out_next;
            r_point       <= w_point_next;
            r_hit_meta    <= bus.CC_BALLCONTROL_hit_InLow;
            r_hit_sync    <= r_hit_meta;
            r_hit_prev    <= r_hit_sync;
        end
    end

    // Outputs are computed for the state being entered so the registers line up with it.
    always_comb begin
        w_state_next       = r_state;
        w_tick_cnt_next    = '0;
        w_win_cnt_next     = r_win_cnt;
        w_shiftsel_next    = 2'b00;
        w_load_next        = '0;
        w_handoff_out_next = 1'b0;
        w_point_next       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.CC_BALLCONTROL_handoff_InHigh) begin
                    w_state_next    = ST_LOAD;
                    w_shiftsel_next = 2'b11;
                    w_load_next     = BALL_SERVE;
                end
            end
            ST_LOAD: w_state_next = ST_MOVE_RIGHT;
            ST_MOVE_RIGHT: begin
                w_tick_cnt_next = w_tick_inc;
                if (w_tick) begin
                    if (!bus.CC_BALLCONTROL_derecha_InLow) begin
                        w_state_next   = ST_WAIT_HIT;
                        w_win_cnt_next = '0;
                    end else begin
                        w_shiftsel_next = 2'b10;
                    end
                end
            end
            ST_WAIT_HIT: begin
                // A hit takes priority over window expiry in the same cycle.
                if (w_hit) begin
                    w_state_next = ST_MOVE_LEFT;
                end else begin
                    w_tick_cnt_next = w_tick_inc;
                    if (w_tick) begin
                        if (r_win_cnt == WIN_LAST) begin
                            w_state_next    = ST_CLEAR;
                            w_shiftsel_next = 2'b11;
                            w_point_next    = 1'b1;
                        end else begin
                            w_win_cnt_next = r_win_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_MOVE_LEFT: begin
                w_tick_cnt_next = w_tick_inc;
                if (w_tick) begin
                    if (!bus.CC_BALLCONTROL_izquierda_InLow) begin
                        w_state_next       = ST_CLEAR;
                        w_shiftsel_next    = 2'b11;
                        w_handoff_out_next = 1'b1;
                    end else begin
                        w_shiftsel_next = 2'b01;
                    end
                end
            end
            ST_CLEAR: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign bus.CC_BALLCONTROL_shiftselection_OutBUS = r_shiftsel;
    assign bus.CC_BALLCONTROL_load_OutBUS           = r_load;
    assign bus.CC_BALLCONTROL_handoff_OutHigh       = r_handoff_out;
    assign bus.CC_BALLCONTROL_point_OutHigh         = r_point;
    assign bus.CC_BALLCONTROL_state_OutBUS          = r_state;

endmodule
